// File: rtl/axi_slave_bridge_pkg.sv
// ---------------------------------------------------------------------------
// axi_slave_bridge_pkg
// Shared definitions for the AXI4-Lite slave front end of the AXI-to-I2C
// bridge: default bus widths, BRESP codes and the write/read FSM state types.
// ---------------------------------------------------------------------------
package axi_slave_bridge_pkg;

  localparam int unsigned AXI_ADDR_W  = 32;
  localparam int unsigned AXI_DATA_W  = 32;
  localparam int unsigned AXI_RDATA_W = 32;
  localparam int unsigned AXI_RESP_W  = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_TRIG = 2'd1,
    R_WAIT = 2'd2,
    R_RESP = 2'd3
  } rd_state_t;

endpackage

// File: rtl/axi_slave_bridge.sv
// ---------------------------------------------------------------------------
// axi_slave_bridge
// AXI4-Lite slave that forwards single-beat writes and reads to a downstream
// I2C master over a shared {addr, data} request bus and returns the result as
// the AXI write response or read data. One write and one read may be in
// flight at once; a pending write request wins the shared bus.
//
// Ports:
//   ACLK, ARESET                      clock, synchronous active-high reset
//   AW*/W*/B*                         AXI write address, data, response
//   AR*/R*                            AXI read address and data (no RRESP)
//   ADDR_DATA_OUT                     request bus {addr, data}, 0 when idle
//   VALID_ADDR_DATA_OUT               write request valid
//   VALID_ADDR_DATA_OUT_ACK[_VALID]   write result (1 = ack) and qualifier
//   I2C_MASTER_TRIGGER                one-cycle read request strobe
//   RDATA_OUT, RDATA_VALID            read data from I2C master
//   RDATA_VALID_ACK                   one-cycle pulse: read data consumed
//   PENDING_TRANSACTION_WR/RD         I2C master busy
// ---------------------------------------------------------------------------
module axi_slave_bridge
  import axi_slave_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH        = AXI_ADDR_W,
  parameter int unsigned DATA_WIDTH        = AXI_DATA_W,
  parameter int unsigned RDATA_WIDTH       = AXI_RDATA_W,
  parameter int unsigned RESPONSE_WIDTH    = AXI_RESP_W,
  parameter int unsigned OUTPUT_ADDR_WIDTH = ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  // write address / data / response
  input  logic                         AWVALID,
  output logic                         AWREADY,
  input  logic [ADDR_WIDTH-1:0]        AWADDR,
  input  logic                         WVALID,
  output logic                         WREADY,
  input  logic [DATA_WIDTH-1:0]        WDATA,
  output logic                         BVALID,
  input  logic                         BREADY,
  output logic [RESPONSE_WIDTH-1:0]    BRESP,
  // read address / data
  input  logic                         ARVALID,
  output logic                         ARREADY,
  input  logic [ADDR_WIDTH-1:0]        ARADDR,
  output logic                         RVALID,
  input  logic                         RREADY,
  output logic [RDATA_WIDTH-1:0]       RDATA,
  // I2C master side
  output logic [OUTPUT_ADDR_WIDTH-1:0] ADDR_DATA_OUT,
  output logic                         VALID_ADDR_DATA_OUT,
  input  logic                         VALID_ADDR_DATA_OUT_ACK,
  input  logic                         VALID_ADDR_DATA_OUT_ACK_VALID,
  output logic                         I2C_MASTER_TRIGGER,
  input  logic [RDATA_WIDTH-1:0]       RDATA_OUT,
  input  logic                         RDATA_VALID,
  output logic                         RDATA_VALID_ACK,
  input  logic                         PENDING_TRANSACTION_WR,
  input  logic                         PENDING_TRANSACTION_RD
);

  wr_state_t                   r_wr_state;
  rd_state_t                   r_rd_state;
  logic                        r_aw_held;
  logic                        r_w_held;
  logic [ADDR_WIDTH-1:0]       r_awaddr;
  logic [DATA_WIDTH-1:0]       r_wdata;
  logic [RESPONSE_WIDTH-1:0]   r_bresp;
  logic                        r_req_active;
  logic [ADDR_WIDTH-1:0]       r_araddr;
  logic [RDATA_WIDTH-1:0]      r_rdata;
  logic                        r_rd_ack;

  logic                        w_awready;
  logic                        w_wready;
  logic                        w_arready;
  logic                        w_aw_hs;
  logic                        w_w_hs;
  logic                        w_ar_hs;
  logic                        w_bus_free;
  logic                        w_wr_valid;
  logic                        w_trig;

  assign w_awready = !ARESET && (r_wr_state == W_IDLE) && !r_aw_held;
  assign w_wready  = !ARESET && (r_wr_state == W_IDLE) && !r_w_held;
  assign w_arready = !ARESET && (r_rd_state == R_IDLE);
  assign w_aw_hs   = AWVALID && w_awready;
  assign w_w_hs    = WVALID  && w_wready;
  assign w_ar_hs   = ARVALID && w_arready;

  assign w_bus_free = !PENDING_TRANSACTION_WR && !PENDING_TRANSACTION_RD;

  // Once the write request has been presented it stays up until acknowledged,
  // even if the I2C master raises a PENDING flag in the meantime.
  assign w_wr_valid = !ARESET && (r_wr_state == W_REQ) && (r_req_active || w_bus_free);

  // The read trigger yields to any write request on the shared bus.
  assign w_trig = !ARESET && (r_rd_state == R_TRIG) && w_bus_free && !w_wr_valid;

  always_comb begin
    ADDR_DATA_OUT = '0;
    if (w_wr_valid) begin
      ADDR_DATA_OUT = OUTPUT_ADDR_WIDTH'({r_awaddr, r_wdata});
    end else if (w_trig) begin
      ADDR_DATA_OUT = OUTPUT_ADDR_WIDTH'({r_araddr, {DATA_WIDTH{1'b0}}});
    end
  end

  assign AWREADY             = w_awready;
  assign WREADY              = w_wready;
  assign ARREADY             = w_arready;
  assign VALID_ADDR_DATA_OUT = w_wr_valid;
  assign I2C_MASTER_TRIGGER  = w_trig;
  assign BVALID              = !ARESET && (r_wr_state == W_RESP);
  assign BRESP               = ARESET ? '0 : r_bresp;
  assign RVALID              = !ARESET && (r_rd_state == R_RESP);
  assign RDATA               = ARESET ? '0 : r_rdata;
  assign RDATA_VALID_ACK     = !ARESET && r_rd_ack;

  // Write FSM
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wr_state   <= W_IDLE;
      r_aw_held    <= 1'b0;
      r_w_held     <= 1'b0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_bresp      <= '0;
      r_req_active <= 1'b0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_awaddr  <= AWADDR;
          end
          if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= WDATA;
          end
          if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
            r_wr_state <= W_REQ;
          end
        end
        W_REQ: begin
          if (w_wr_valid) begin
            if (VALID_ADDR_DATA_OUT_ACK_VALID) begin
              r_bresp      <= VALID_ADDR_DATA_OUT_ACK ? RESPONSE_WIDTH'(RESP_OKAY)
                                                      : RESPONSE_WIDTH'(RESP_SLVERR);
              r_req_active <= 1'b0;
              r_wr_state   <= W_RESP;
            end else begin
              r_req_active <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_wr_state <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM; RDATA_VALID is only looked at in R_WAIT so a stale level from
  // an earlier read cannot complete a new one before its trigger is issued.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rd_state <= R_IDLE;
      r_araddr   <= '0;
      r_rdata    <= '0;
      r_rd_ack   <= 1'b0;
    end else begin
      r_rd_ack <= 1'b0;
      case (r_rd_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_araddr   <= ARADDR;
            r_rd_state <= R_TRIG;
          end
        end
        R_TRIG: begin
          if (w_trig) begin
            r_rd_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (RDATA_VALID) begin
            r_rdata    <= RDATA_OUT;
            r_rd_ack   <= 1'b1;
            r_rd_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            r_rd_state <= R_IDLE;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_bridge.sv
// ---------------------------------------------------------------------------
// tb_axi_slave_bridge
// Directed bench for axi_slave_bridge. Inputs change and outputs are checked
// 1 ns after each rising clock edge.
// ---------------------------------------------------------------------------
module tb_axi_slave_bridge;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        AWVALID, AWREADY;
  logic [31:0] AWADDR;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic        RVALID, RREADY;
  logic [31:0] RDATA;
  logic [63:0] ADDR_DATA_OUT;
  logic        VALID_ADDR_DATA_OUT;
  logic        VALID_ADDR_DATA_OUT_ACK;
  logic        VALID_ADDR_DATA_OUT_ACK_VALID;
  logic        I2C_MASTER_TRIGGER;
  logic [31:0] RDATA_OUT;
  logic        RDATA_VALID;
  logic        RDATA_VALID_ACK;
  logic        PENDING_TRANSACTION_WR;
  logic        PENDING_TRANSACTION_RD;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 ACLK = ~ACLK;

  axi_slave_bridge #(
    .ADDR_WIDTH       (32),
    .DATA_WIDTH       (32),
    .RDATA_WIDTH      (32),
    .RESPONSE_WIDTH   (2),
    .OUTPUT_ADDR_WIDTH(64)
  ) dut (
    .ACLK                         (ACLK),
    .ARESET                       (ARESET),
    .AWVALID                      (AWVALID),
    .AWREADY                      (AWREADY),
    .AWADDR                       (AWADDR),
    .WVALID                       (WVALID),
    .WREADY                       (WREADY),
    .WDATA                        (WDATA),
    .BVALID                       (BVALID),
    .BREADY                       (BREADY),
    .BRESP                        (BRESP),
    .ARVALID                      (ARVALID),
    .ARREADY                      (ARREADY),
    .ARADDR                       (ARADDR),
    .RVALID                       (RVALID),
    .RREADY                       (RREADY),
    .RDATA                        (RDATA),
    .ADDR_DATA_OUT                (ADDR_DATA_OUT),
    .VALID_ADDR_DATA_OUT          (VALID_ADDR_DATA_OUT),
    .VALID_ADDR_DATA_OUT_ACK      (VALID_ADDR_DATA_OUT_ACK),
    .VALID_ADDR_DATA_OUT_ACK_VALID(VALID_ADDR_DATA_OUT_ACK_VALID),
    .I2C_MASTER_TRIGGER           (I2C_MASTER_TRIGGER),
    .RDATA_OUT                    (RDATA_OUT),
    .RDATA_VALID                  (RDATA_VALID),
    .RDATA_VALID_ACK              (RDATA_VALID_ACK),
    .PENDING_TRANSACTION_WR       (PENDING_TRANSACTION_WR),
    .PENDING_TRANSACTION_RD       (PENDING_TRANSACTION_RD)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    ARESET = 1'b1;
    AWVALID = 1'b0; AWADDR = '0; WVALID = 1'b0; WDATA = '0; BREADY = 1'b0;
    ARVALID = 1'b0; ARADDR = '0; RREADY = 1'b0;
    VALID_ADDR_DATA_OUT_ACK = 1'b0; VALID_ADDR_DATA_OUT_ACK_VALID = 1'b0;
    RDATA_OUT = '0; RDATA_VALID = 1'b0;
    PENDING_TRANSACTION_WR = 1'b0; PENDING_TRANSACTION_RD = 1'b0;

    // reset
    tick(); tick();
    check_val("rst_awready", AWREADY, 0);
    check_val("rst_arready", ARREADY, 0);
    check_val("rst_valid",   VALID_ADDR_DATA_OUT, 0);
    check_val("rst_bvalid",  BVALID, 0);
    ARESET = 1'b0;
    tick();
    check_val("rel_ready", {AWREADY, WREADY, ARREADY}, 3'b111);

    // 1: AW and W together, acked
    AWVALID = 1'b1; AWADDR = 32'h1234_0001; WVALID = 1'b1; WDATA = 32'h1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    check_val("w1_valid",   VALID_ADDR_DATA_OUT, 1);
    check_val("w1_addr",    ADDR_DATA_OUT, 64'h1234_0001_0000_0001);
    check_val("w1_awready", AWREADY, 0);
    VALID_ADDR_DATA_OUT_ACK = 1'b1; VALID_ADDR_DATA_OUT_ACK_VALID = 1'b1; BREADY = 1'b1;
    tick();
    VALID_ADDR_DATA_OUT_ACK_VALID = 1'b0;
    check_val("w1_bvalid", BVALID, 1);
    check_val("w1_bresp",  BRESP, 2'b00);
    check_val("w1_valid_off", VALID_ADDR_DATA_OUT, 0);
    tick();
    check_val("w1_bvalid_once", BVALID, 0);
    check_val("w1_idle_awready", AWREADY, 1);

    // 2: W before AW
    WVALID = 1'b1; WDATA = 32'h2;
    tick();
    WVALID = 1'b0;
    check_val("w2_wready",  WREADY, 0);
    check_val("w2_awready", AWREADY, 1);
    check_val("w2_novalid", VALID_ADDR_DATA_OUT, 0);
    AWVALID = 1'b1; AWADDR = 32'h1234_AA1D;
    tick();
    AWVALID = 1'b0;
    check_val("w2_awready_drop", AWREADY, 0);
    check_val("w2_valid", VALID_ADDR_DATA_OUT, 1);
    check_val("w2_addr",  ADDR_DATA_OUT, 64'h1234_AA1D_0000_0002);
    VALID_ADDR_DATA_OUT_ACK_VALID = 1'b1;
    tick();
    VALID_ADDR_DATA_OUT_ACK_VALID = 1'b0;
    check_val("w2_bvalid", BVALID, 1);
    tick();

    // 3: PENDING holds off the request, then NACK -> SLVERR
    PENDING_TRANSACTION_WR = 1'b1;
    AWVALID = 1'b1; AWADDR = 32'h10; WVALID = 1'b1; WDATA = 32'h20;
    tick();
    WVALID = 1'b0;
    AWADDR = 32'hDEAD;  // not ready: must not replace the held address
    check_val("w3_blocked", VALID_ADDR_DATA_OUT, 0);
    check_val("w3_bus_idle", ADDR_DATA_OUT, 64'h0);
    tick();
    AWVALID = 1'b0;
    check_val("w3_blocked2", VALID_ADDR_DATA_OUT, 0);
    PENDING_TRANSACTION_WR = 1'b0;
    #1;
    check_val("w3_valid", VALID_ADDR_DATA_OUT, 1);
    check_val("w3_addr",  ADDR_DATA_OUT, 64'h0000_0010_0000_0020);
    tick();
    PENDING_TRANSACTION_WR = 1'b1;
    #1;
    check_val("w3_hold", VALID_ADDR_DATA_OUT, 1);
    VALID_ADDR_DATA_OUT_ACK = 1'b0; VALID_ADDR_DATA_OUT_ACK_VALID = 1'b1;
    tick();
    VALID_ADDR_DATA_OUT_ACK_VALID = 1'b0; PENDING_TRANSACTION_WR = 1'b0;
    check_val("w3_bvalid", BVALID, 1);
    check_val("w3_bresp",  BRESP, 2'b10);
    tick();
    check_val("w3_done", BVALID, 0);

    // 4: read
    ARVALID = 1'b1; ARADDR = 32'h2;
    tick();
    ARVALID = 1'b0;
    check_val("r1_arready", ARREADY, 0);
    check_val("r1_trig",    I2C_MASTER_TRIGGER, 1);
    check_val("r1_addr",    ADDR_DATA_OUT, 64'h0000_0002_0000_0000);
    tick();
    check_val("r1_trig_once", I2C_MASTER_TRIGGER, 0);
    RDATA_OUT = 32'hA; RDATA_VALID = 1'b1;
    tick();
    RDATA_VALID = 1'b0;
    check_val("r1_rvalid", RVALID, 1);
    check_val("r1_rdata",  RDATA, 32'hA);
    check_val("r1_ack",    RDATA_VALID_ACK, 1);
    tick();
    check_val("r1_ack_once", RDATA_VALID_ACK, 0);
    check_val("r1_rvalid_hold", RVALID, 1);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check_val("r1_done", RVALID, 0);
    check_val("r1_arready_back", ARREADY, 1);

    // stale RDATA_VALID level is not taken before the trigger
    RDATA_OUT = 32'hB; RDATA_VALID = 1'b1;
    ARVALID = 1'b1; ARADDR = 32'h7;
    tick();
    ARVALID = 1'b0;
    check_val("r2_trig", I2C_MASTER_TRIGGER, 1);
    check_val("r2_no_rvalid", RVALID, 0);
    tick();
    check_val("r2_no_rvalid2", RVALID, 0);
    tick();
    RDATA_VALID = 1'b0;
    check_val("r2_rvalid", RVALID, 1);
    check_val("r2_rdata",  RDATA, 32'hB);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;

    // 5: write and read in the same cycle
    BREADY = 1'b0;
    AWVALID = 1'b1; AWADDR = 32'h55; WVALID = 1'b1; WDATA = 32'h66;
    ARVALID = 1'b1; ARADDR = 32'h77;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    check_val("a_wr_first", VALID_ADDR_DATA_OUT, 1);
    check_val("a_no_trig",  I2C_MASTER_TRIGGER, 0);
    check_val("a_addr_wr",  ADDR_DATA_OUT, 64'h0000_0055_0000_0066);
    tick();
    check_val("a_no_trig2", I2C_MASTER_TRIGGER, 0);
    VALID_ADDR_DATA_OUT_ACK = 1'b1; VALID_ADDR_DATA_OUT_ACK_VALID = 1'b1;
    tick();
    VALID_ADDR_DATA_OUT_ACK_VALID = 1'b0;
    check_val("a_bvalid", BVALID, 1);
    check_val("a_trig",   I2C_MASTER_TRIGGER, 1);
    check_val("a_addr_rd", ADDR_DATA_OUT, 64'h0000_0077_0000_0000);
    BREADY = 1'b1;
    tick();
    check_val("a_trig_once", I2C_MASTER_TRIGGER, 0);
    check_val("a_bdone", BVALID, 0);
    RDATA_OUT = 32'hC; RDATA_VALID = 1'b1; RREADY = 1'b1;
    tick();
    RDATA_VALID = 1'b0;
    check_val("a_rdata", RDATA, 32'hC);
    tick();
    RREADY = 1'b0;

    // 6: reset during W_REQ aborts the write
    AWVALID = 1'b1; AWADDR = 32'h99; WVALID = 1'b1; WDATA = 32'h98;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    check_val("x_valid", VALID_ADDR_DATA_OUT, 1);
    ARESET = 1'b1; VALID_ADDR_DATA_OUT_ACK_VALID = 1'b1;
    tick();
    VALID_ADDR_DATA_OUT_ACK_VALID = 1'b0;
    check_val("x_valid_off", VALID_ADDR_DATA_OUT, 0);
    check_val("x_no_bvalid", BVALID, 0);
    ARESET = 1'b0;
    tick();
    check_val("x_no_bvalid2", BVALID, 0);
    check_val("x_idle_valid", VALID_ADDR_DATA_OUT, 0);
    check_val("x_awready", AWREADY, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_slave_bridge.md
# axi_slave_bridge

AXI4-Lite slave front end of the AXI-to-I2C bridge. Accepts single-beat AXI writes and reads, forwards each as a request to the downstream I2C master, and returns the I2C result as the AXI write response or read data. One write and one read may be in flight at once; the shared request bus is arbitrated internally.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI write data width
- RDATA_WIDTH, 32, read data width
- RESPONSE_WIDTH, 2, BRESP width
- OUTPUT_ADDR_WIDTH, ADDR_WIDTH+DATA_WIDTH, request bus width

Ports (one clock; reset is synchronous and active-high):
- ACLK  in  1  clock
- ARESET  in  1  synchronous active-high reset
- AWVALID/AWREADY  in/out  1  write address handshake; AWADDR  in  ADDR_WIDTH
- WVALID/WREADY  in/out  1  write data handshake; WDATA  in  DATA_WIDTH
- BVALID/BREADY  out/in  1  write response handshake; BRESP  out  RESPONSE_WIDTH
- ARVALID/ARREADY  in/out  1  read address handshake; ARADDR  in  ADDR_WIDTH
- RVALID/RREADY  out/in  1  read data handshake; RDATA  out  RDATA_WIDTH
- ADDR_DATA_OUT  out  OUTPUT_ADDR_WIDTH  request to I2C master, {addr, data}
- VALID_ADDR_DATA_OUT  out  1  write request valid
- VALID_ADDR_DATA_OUT_ACK  in  1  I2C write result (1 = ack, 0 = nack)
- VALID_ADDR_DATA_OUT_ACK_VALID  in  1  qualifies VALID_ADDR_DATA_OUT_ACK
- I2C_MASTER_TRIGGER  out  1  one-cycle read request strobe
- RDATA_OUT  in  RDATA_WIDTH  read data from I2C master
- RDATA_VALID  in  1  RDATA_OUT valid
- RDATA_VALID_ACK  out  1  one-cycle pulse: read data consumed
- PENDING_TRANSACTION_WR, PENDING_TRANSACTION_RD  in  1  I2C master busy

## Operation
- Write FSM W_IDLE -> W_REQ -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1 until an address is held, WREADY=1 until data is held; AW and W accepted independently, in either order or the same cycle. Both held -> W_REQ.
  - W_REQ: once both PENDING inputs are low, assert VALID_ADDR_DATA_OUT with ADDR_DATA_OUT={awaddr, wdata}; once asserted, hold it until ACK_VALID=1 regardless of PENDING. On ACK_VALID: BRESP=2'b00 if ACK=1, else 2'b10 (SLVERR) -> W_RESP.
  - W_RESP: BVALID=1, BRESP stable; BREADY -> W_IDLE, held flags cleared.
- Read FSM R_IDLE -> R_TRIG -> R_WAIT -> R_RESP -> R_IDLE.
  - R_IDLE: ARREADY=1; handshake captures ARADDR.
  - R_TRIG: when both PENDING inputs are low and the write FSM is not driving the bus, pulse I2C_MASTER_TRIGGER one cycle with ADDR_DATA_OUT={araddr, 0} -> R_WAIT.
  - R_WAIT: RDATA_VALID=1 samples RDATA_OUT into RDATA, pulses RDATA_VALID_ACK one cycle -> R_RESP.
  - R_RESP: RVALID=1; RREADY -> R_IDLE. No RRESP port; reads always succeed.
- Arbitration: write request wins over a same-cycle read trigger; trigger is withheld while VALID_ADDR_DATA_OUT=1.
- ADDR_DATA_OUT drives 0 when no request is active.

## Timing
- ARESET high: both FSMs idle, held flags cleared, all outputs 0, including the READYs (gated by !ARESET). First cycle after release: AWREADY=WREADY=ARREADY=1.
- AW and W handshakes complete at the same edge -> VALID_ADDR_DATA_OUT high the next cycle (PENDING low).
- ACK_VALID sampled at edge N -> BVALID from cycle N+1; BREADY already high -> W_IDLE at N+2.
- AR handshake at edge N -> trigger in cycle N+1 (unblocked).
- RDATA_VALID sampled at edge M -> RVALID and RDATA_VALID_ACK in cycle M+1.
- RDATA_VALID is ignored outside R_WAIT, so a level left high from an earlier read is not taken until after the trigger cycle.
- AWVALID/WVALID while not ready are not accepted and have no effect.
- ARESET mid-transaction aborts it; no response is issued.

## Structure
- Package axi_slave_bridge_pkg: width constants, BRESP codes (OKAY=2'b00, SLVERR=2'b10), write/read state enums.
- Single module; write and read FSMs as separate always blocks. No sub-module needed.

## Test plan
- AWADDR=0x1234_0001 with WDATA=0x1 in the same cycle, ACK=ACK_VALID=1 -> ADDR_DATA_OUT=0x1234_0001_0000_0001, BRESP=00, one BVALID.
- W before AW (WDATA=0x2, then AWADDR=0x1234_AA1D) -> single request carrying both, AWREADY drops after capture.
- ACK_VALID=1 with ACK=0 -> BRESP=10; PENDING_TRANSACTION_WR held high before the request -> VALID_ADDR_DATA_OUT stays low until it falls.
- ARADDR=0x2 -> one-cycle trigger with ADDR_DATA_OUT=0x0000_0002_0000_0000; RDATA_OUT=0xA with RDATA_VALID -> RDATA=0xA, RVALID, one RDATA_VALID_ACK pulse; RVALID held until RREADY.
- Write and read issued in the same cycle -> VALID_ADDR_DATA_OUT first; trigger after ACK_VALID.
- Reset asserted in W_REQ -> VALID_ADDR_DATA_OUT low the next cycle, no BVALID.
